// File: rtl/soml_stbc_encoder_if.sv
// Handshake and sample bus between the SOML STBC encoder and its neighbours.
// The encoder uses the slave view; the block feeding it and draining it uses the master view.
interface soml_stbc_encoder_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_bits;
    logic             out_valid;
    logic             out_ready;
    logic             out_slot;
    logic [N-1:0]     tx1_i;
    logic [N-1:0]     tx1_q;
    logic [N-1:0]     tx2_i;
    logic [N-1:0]     tx2_q;
    logic [CNT_W-1:0] blk_cnt;

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_slot,
        output tx1_i, tx1_q, tx2_i, tx2_q, blk_cnt
    );

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_slot,
        input  tx1_i, tx1_q, tx2_i, tx2_q, blk_cnt
    );
endinterface

// File: rtl/soml_stbc_encoder.sv
// 2-antenna Alamouti encoder for pairs of 16-QAM symbols, emitted over two handshaked slots.
// Define SOML_ENC_GRAY_EN to switch the 2-bit field to 4-PAM mapping from natural binary to Gray.
module soml_stbc_encoder #(
    parameter int N     = 32,
    parameter int Q     = 22,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    soml_stbc_encoder_if.slave   bus
);

    if (Q > N - 3) begin : g_param_check
        $error("soml_stbc_encoder: Q must not exceed N-3");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT0 = 2'd1,
        SLOT1 = 2'd2
    } state_e;

    localparam logic signed [N-1:0] LVL_P1 = N'(1) << Q;
    localparam logic signed [N-1:0] LVL_P3 = N'(3) << Q;
    localparam logic signed [N-1:0] LVL_M1 = -LVL_P1;
    localparam logic signed [N-1:0] LVL_M3 = -LVL_P3;

    state_e                 state_q, state_d;
    logic signed [N-1:0]    lvl_q [4];
    logic signed [N-1:0]    lvl_d [4];
    logic signed [N-1:0]    new_lvl [4];
    logic signed [N-1:0]    tx_q [4];
    logic signed [N-1:0]    tx_d [4];
    logic [CNT_W-1:0]       blk_cnt_q, blk_cnt_d;
    logic                   in_ready;
    logic                   accept;

    // Field order in new_lvl/lvl_q: 0=I1, 1=Q1, 2=I2, 3=Q2 (MSB pair first).
    for (genvar gi = 0; gi < 4; gi++) begin : g_map
        logic [1:0] field;
        logic [1:0] idx;
        assign field = bus.in_bits[7-2*gi -: 2];
`ifdef SOML_ENC_GRAY_EN
        assign idx = {field[1], field[1] ^ field[0]};
`else
        assign idx = field;
`endif
        assign new_lvl[gi] = (idx == 2'd0) ? LVL_M3 :
                             (idx == 2'd1) ? LVL_M1 :
                             (idx == 2'd2) ? LVL_P1 : LVL_P3;
    end

    assign in_ready = (state_q == IDLE) || ((state_q == SLOT1) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        lvl_d     = lvl_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    lvl_d   = new_lvl;
                    tx_d    = new_lvl;
                    state_d = SLOT0;
                end
            end
            SLOT0: begin
                // Second slot: tx1 = -conj(s2), tx2 = conj(s1).
                if (bus.out_ready) begin
                    tx_d[0] = -lvl_q[2];
                    tx_d[1] =  lvl_q[3];
                    tx_d[2] =  lvl_q[0];
                    tx_d[3] = -lvl_q[1];
                    state_d = SLOT1;
                end
            end
            SLOT1: begin
                if (bus.out_ready) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    if (accept) begin
                        lvl_d   = new_lvl;
                        tx_d    = new_lvl;
                        state_d = SLOT0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            blk_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                lvl_q[i] <= '0;
                tx_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            lvl_q     <= lvl_d;
            tx_q      <= tx_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q != IDLE);
    assign bus.out_slot  = (state_q == SLOT1);
    assign bus.tx1_i     = tx_q[0];
    assign bus.tx1_q     = tx_q[1];
    assign bus.tx2_i     = tx_q[2];
    assign bus.tx2_q     = tx_q[3];
    assign bus.blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_soml_stbc_encoder.sv
// Scoreboard bench for soml_stbc_encoder: the driver pushes expected Alamouti slots per accepted
// block, the monitor checks the outputs every cycle; a second instance with CNT_W=2 checks counter wrap.
module tb_soml_stbc_encoder;
    localparam int N = 32;
    localparam int Q = 22;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    soml_stbc_encoder_if #(.N(N), .CNT_W(16)) bus ();
    soml_stbc_encoder_if #(.N(N), .CNT_W(2))  bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_bits   = bus.in_bits;
    assign bus2.out_ready = bus.out_ready;

    soml_stbc_encoder #(.N(N), .Q(Q), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    soml_stbc_encoder #(.N(N), .Q(Q), .CNT_W(2)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic         slot;
        logic [N-1:0] t0;
        logic [N-1:0] t1;
        logic [N-1:0] t2;
        logic [N-1:0] t3;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 4-PAM level of one 2-bit field, straight from the mapping tables.
    function automatic int ref_level(input logic [1:0] f);
`ifdef SOML_ENC_GRAY_EN
        int tbl[4];
        tbl = '{-3, -1, 3, 1};
        return tbl[f];
`else
        return 2 * int'(f) - 3;
`endif
    endfunction

    function automatic logic [N-1:0] smp(input int lvl);
        return N'(lvl * (1 << Q));
    endfunction

    task automatic push_block(input logic [7:0] b);
        int i1, q1, i2, q2;
        exp_t e;
        i1 = ref_level(b[7:6]);
        q1 = ref_level(b[5:4]);
        i2 = ref_level(b[3:2]);
        q2 = ref_level(b[1:0]);
        e.slot = 1'b0; e.t0 = smp(i1);  e.t1 = smp(q1); e.t2 = smp(i2); e.t3 = smp(q2);
        sb.push_back(e);
        e.slot = 1'b1; e.t0 = smp(-i2); e.t1 = smp(q2); e.t2 = smp(i1); e.t3 = smp(-q1);
        sb.push_back(e);
        $display("accept bits=%b levels I1=%0d Q1=%0d I2=%0d Q2=%0d", b, i1, q1, i2, q2);
    endtask

    // Called at posedge+1; applies inputs for one cycle and records an accept.
    task automatic step(input logic v, input logic [7:0] b, input logic r);
        logic fire;
        bus.in_valid  = v;
        bus.in_bits   = b;
        bus.out_ready = r;
        @(negedge clk);
        fire = v && bus.in_ready;
        @(posedge clk);
        #1;
        if (fire) push_block(b);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_slot"},  32'(bus.out_slot),  32'd0);
        chk({tag, "_tx1_i"},     bus.tx1_i,          32'd0);
        chk({tag, "_tx1_q"},     bus.tx1_q,          32'd0);
        chk({tag, "_tx2_i"},     bus.tx2_i,          32'd0);
        chk({tag, "_tx2_q"},     bus.tx2_q,          32'd0);
        chk({tag, "_blk_cnt"},   32'(bus.blk_cnt),   32'd0);
    endtask

    // Monitor: expected state is derived purely from the scoreboard queue.
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        logic exp_valid;
        logic exp_rdy;
        if (!rst_n) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            exp_valid = (sb.size() != 0);
            exp_rdy   = 1'b1;
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid) begin
                e = sb[0];
                chk("out_slot", 32'(bus.out_slot), 32'(e.slot));
                chk("tx1_i", bus.tx1_i, e.t0);
                chk("tx1_q", bus.tx1_q, e.t1);
                chk("tx2_i", bus.tx2_i, e.t2);
                chk("tx2_q", bus.tx2_q, e.t3);
                exp_rdy = e.slot && bus.out_ready;
            end
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("blk_cnt", 32'(bus.blk_cnt), 32'(model_cnt % 65536));
            chk("blk_cnt_wrap", 32'(bus2.blk_cnt), 32'(model_cnt % 4));
            if (exp_valid && bus.out_ready) begin
                void'(sb.pop_front());
                if (e.slot) begin
                    model_cnt++;
                    $display("block done count=%0d", model_cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_bits   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Single block, downstream always ready.
        step(1'b1, 8'b00_01_10_11, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'b11_10_01_00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Stall in SLOT0 for 5 cycles with in_valid asserted and changing bits.
        step(1'b1, 8'b00_01_10_11, 1'b0);
        repeat (5) step(1'b1, 8'($urandom), 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Back-to-back blocks with both sides always ready.
        repeat (7) step(1'b1, 8'($urandom), 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Random traffic.
        repeat (300) step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        repeat (4) step(1'b0, 8'h00, 1'b1);

        // Reset while the block sits in SLOT1.
        step(1'b1, 8'($urandom), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        bus.out_ready = 1'b0;
        #2;
        chk("pre_rst_out_slot", 32'(bus.out_slot), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        chk("midrst_wrap_cnt", 32'(bus2.blk_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Traffic after reset must encode correctly.
        step(1'b1, 8'b00_01_10_11, 1'b1);
        repeat (150) step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) != 0);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
